// File: rtl/pc_sequencer_pkg.sv
// Shared pipeline definitions for the fetch-PC sequencer: state encoding,
// fetch increment, default boot address and target alignment helper.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHold,
        StPend
    } seq_state_e;

    localparam logic [31:0] PcIncr         = 32'd4;
    localparam logic [31:0] DefaultResetPc = 32'h0000_2000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: sequential fetch, EX-stage redirects, stall freeze with a
// captured pending redirect, sticky misalignment flag and redirect counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             ImemReady,
    input  logic             ExValid,
    input  logic             Diverge,
    input  logic [31:0]      Target,
    output logic [31:0]      PC,
    output logic             FetchValid,
    output logic             FlushD,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] RedirectCount
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        mis_q, mis_d;
    logic        redirect;
    logic        accept;
    logic        fetch_valid;
    logic        flush;

    assign redirect = ExValid & Diverge;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                fetch_valid = 1'b1;
                if (!Stall) begin
                    if (redirect) begin
                        accept = 1'b1;
                        flush  = 1'b1;
                        pc_d   = align_word(Target);
                    end else if (ImemReady) begin
                        pc_d = pc_q + PcIncr;
                    end
                end else if (redirect) begin
                    accept  = 1'b1;
                    tgt_d   = align_word(Target);
                    state_d = StPend;
                end else begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect) begin
                    accept  = 1'b1;
                    tgt_d   = align_word(Target);
                    state_d = StPend;
                end else if (!Stall) begin
                    state_d = StRun;
                end
            end
            StPend: begin
                // EX is frozen on the redirecting instruction, so Diverge is ignored here.
                if (!Stall) begin
                    pc_d    = tgt_q;
                    flush   = 1'b1;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
        mis_d = mis_q | (accept & (Target[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            mis_q   <= mis_d;
        end
    end

    sat_counter #(
        .Width (CNT_W)
    ) u_redirect_cnt (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (accept),
        .count_o (RedirectCount)
    );

    assign PC          = pc_q;
    assign FetchValid  = fetch_valid;
    assign FlushD      = flush;
    assign MisalignErr = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset/wrap
// sequences, and randomized stimulus against a flag-based reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall, ImemReady, ExValid, Diverge;
    logic [31:0] Target;
    logic [31:0] PC, pc2;
    logic        FetchValid, FlushD, MisalignErr, fv2, fl2, mis2;
    logic [15:0] RedirectCount;
    logic [1:0]  cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Stall         (Stall),
        .ImemReady     (ImemReady),
        .ExValid       (ExValid),
        .Diverge       (Diverge),
        .Target        (Target),
        .PC            (PC),
        .FetchValid    (FetchValid),
        .FlushD        (FlushD),
        .MisalignErr   (MisalignErr),
        .RedirectCount (RedirectCount)
    );

    pc_sequencer #(
        .CNT_W (2)
    ) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .Stall         (Stall),
        .ImemReady     (ImemReady),
        .ExValid       (ExValid),
        .Diverge       (Diverge),
        .Target        (Target),
        .PC            (pc2),
        .FetchValid    (fv2),
        .FlushD        (fl2),
        .MisalignErr   (mis2),
        .RedirectCount (cnt2)
    );

    typedef struct {
        logic        st, rd, ev, dv;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        fv, fl, mis;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic fv,
                             input logic fl, input logic mis, input int cnt);
        int sat2;
        sat2 = (cnt > 3) ? 3 : cnt;
        vectors++;
        chk({tag, ".PC"}, PC, pc);
        chk({tag, ".FetchValid"}, {31'd0, FetchValid}, {31'd0, fv});
        chk({tag, ".FlushD"}, {31'd0, FlushD}, {31'd0, fl});
        chk({tag, ".MisalignErr"}, {31'd0, MisalignErr}, {31'd0, mis});
        chk({tag, ".RedirectCount"}, {16'd0, RedirectCount}, 32'(cnt));
        chk({tag, ".w2.PC"}, pc2, pc);
        chk({tag, ".w2.FetchValid"}, {31'd0, fv2}, {31'd0, fv});
        chk({tag, ".w2.FlushD"}, {31'd0, fl2}, {31'd0, fl});
        chk({tag, ".w2.MisalignErr"}, {31'd0, mis2}, {31'd0, mis});
        chk({tag, ".w2.RedirectCount"}, {30'd0, cnt2}, 32'(sat2));
    endtask

    task automatic drive(input logic st, input logic rd, input logic ev, input logic dv,
                         input logic [31:0] tg);
        Stall     = st;
        ImemReady = rd;
        ExValid   = ev;
        Diverge   = dv;
        Target    = tg;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds reset across two edges, checks the reset state, releases at posedge+1.
    task automatic do_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check_all("reset", 32'h0000_2000, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    task automatic step_check(input string tag, input logic st, input logic rd, input logic ev,
                              input logic dv, input logic [31:0] tg, input logic [31:0] pc,
                              input logic fv, input logic fl, input logic mis, input int cnt);
        drive(st, rd, ev, dv, tg);
        @(negedge clk);
        check_all(tag, pc, fv, fl, mis, cnt);
        tick();
    endtask

    // Reference model state: boot cycle pending, frozen without/with a captured target.
    bit          m_boot, m_hold, m_pend, m_mis;
    logic [31:0] m_pc, m_tgt;
    int          m_cnt;

    initial begin
        tbl.push_back('{0, 1, 0, 0, 32'h0,         32'h0000_2000, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 32'h0,         32'h0000_2000, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 32'h0,         32'h0000_2004, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 32'h0,         32'h0000_2008, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 32'h0,         32'h0000_200C, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 32'h0000_3000, 32'h0000_2010, 1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 32'h0,         32'h0000_3000, 1, 0, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 32'h0,         32'h0000_3000, 1, 0, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 32'h0000_4000, 32'h0000_3000, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 32'h0000_6000, 32'h0000_3000, 0, 0, 0, 2});
        tbl.push_back('{0, 1, 0, 0, 32'h0,         32'h0000_3000, 0, 1, 0, 2});
        tbl.push_back('{0, 1, 1, 1, 32'h0000_5002, 32'h0000_4000, 1, 1, 0, 2});
        tbl.push_back('{0, 1, 0, 1, 32'h0000_9000, 32'h0000_5000, 1, 0, 1, 3});
        tbl.push_back('{0, 1, 0, 0, 32'h0,         32'h0000_5004, 1, 0, 1, 3});

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step_check($sformatf("tbl%0d", i), tbl[i].st, tbl[i].rd, tbl[i].ev, tbl[i].dv,
                       tbl[i].tgt, tbl[i].pc, tbl[i].fv, tbl[i].fl, tbl[i].mis, tbl[i].cnt);
        end

        // Sticky misalign over idle cycles, then counter saturation and PC wrap.
        for (int i = 0; i < 10; i++) begin
            step_check("sticky", 0, 0, 0, 0, 32'h0, 32'h0000_5008, 1, 0, 1, 3);
        end
        step_check("sat_a", 0, 1, 1, 1, 32'h0000_7000, 32'h0000_5008, 1, 1, 1, 3);
        step_check("sat_b", 0, 1, 1, 1, 32'h0000_7104, 32'h0000_7000, 1, 1, 1, 4);
        step_check("sat_c", 0, 1, 1, 1, 32'hFFFF_FFF8, 32'h0000_7104, 1, 1, 1, 5);
        step_check("wrap_a", 0, 1, 0, 0, 32'h0, 32'hFFFF_FFF8, 1, 0, 1, 6);
        step_check("wrap_b", 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 1, 6);
        step_check("wrap_c", 0, 1, 0, 0, 32'h0, 32'h0000_0000, 1, 0, 1, 6);

        // Asynchronous reset while a captured redirect is pending.
        do_reset();
        step_check("p_boot", 0, 1, 0, 0, 32'h0, 32'h0000_2000, 0, 0, 0, 0);
        step_check("p_run0", 0, 1, 0, 0, 32'h0, 32'h0000_2000, 1, 0, 0, 0);
        step_check("p_run1", 0, 1, 0, 0, 32'h0, 32'h0000_2004, 1, 0, 0, 0);
        step_check("p_cap",  1, 1, 1, 1, 32'h0000_8001, 32'h0000_2008, 1, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_all("p_pend", 32'h0000_2008, 1'b0, 1'b0, 1'b1, 1);
        #2 rst_n = 1'b0;
        #1 check_all("p_async", 32'h0000_2000, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        step_check("p_boot2", 0, 1, 0, 0, 32'h0, 32'h0000_2000, 0, 0, 0, 0);
        step_check("p_run2",  0, 1, 0, 0, 32'h0, 32'h0000_2000, 1, 0, 0, 0);
        step_check("p_run3",  0, 1, 0, 0, 32'h0, 32'h0000_2004, 1, 0, 0, 0);

        // Randomized run against the reference model.
        do_reset();
        m_boot = 1; m_hold = 0; m_pend = 0; m_mis = 0;
        m_pc = 32'h0000_2000; m_tgt = 32'h0; m_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            logic        st, rd, ev, dv, redir, e_fv, e_fl;
            logic [31:0] tg;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
            ev = $urandom_range(0, 1) == 1;
            dv = ($urandom_range(0, 2) == 0);
            tg = $urandom;
            if ($urandom_range(0, 7) != 0) tg[1:0] = 2'b00;
            redir = ev & dv;
            e_fv  = !m_boot && !m_hold && !m_pend;
            e_fl  = (e_fv && !st && redir) || (m_pend && !st);
            drive(st, rd, ev, dv, tg);
            @(negedge clk);
            check_all($sformatf("rnd%0d", i), m_pc, e_fv, e_fl, m_mis, m_cnt);
            tick();
            if (m_boot) begin
                m_boot = 0;
            end else if (m_pend) begin
                if (!st) begin
                    m_pc   = m_tgt;
                    m_pend = 0;
                end
            end else if (redir) begin
                m_cnt++;
                if (tg[1:0] != 2'b00) m_mis = 1;
                if (st || m_hold) begin
                    m_tgt  = tg & ~32'h3;
                    m_pend = 1;
                    m_hold = 0;
                end else begin
                    m_pc = tg & ~32'h3;
                end
            end else if (m_hold) begin
                if (!st) m_hold = 0;
            end else if (st) begin
                m_hold = 1;
            end else if (rd) begin
                m_pc = m_pc + 32'd4;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
